// File: rtl/cpu_types_pkg.sv
// Shared MIPS core types: data word, RAM status and the RAM arbiter state encoding.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2,
        SCFAIL = 2'd3
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester + RAM side signals of the RAM arbiter; slave is the arbiter, master the environment.
interface ram_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    word_t     iload;
    logic      iwait;
    logic      dREN;
    logic      dWEN;
    logic      datomic;
    word_t     daddr;
    word_t     dstore;
    word_t     dload;
    logic      dwait;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
    );

endinterface

// File: rtl/llsc_link.sv
// LL/SC reservation: link address plus valid bit, updated on data-access completions.
module llsc_link
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  rd_done,
    input  logic  wr_done,
    input  logic  scfail_done,
    input  logic  datomic,
    input  word_t daddr,
    output logic  sc_ok
);

    word_t link;
    logic  valid;

    // LL arms the link; any SC, or a plain store to the linked word, breaks it
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            link  <= '0;
            valid <= 1'b0;
        end else if (rd_done && datomic) begin
            link  <= daddr;
            valid <= 1'b1;
        end else if (scfail_done || (wr_done && (datomic || (daddr == link)))) begin
            valid <= 1'b0;
        end
    end

    assign sc_ok = valid && (link == daddr);

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the single RAM port between fetch and data requesters, data first.
// Optional LL/SC reservation tracking is enabled with the LLSC_EN macro.
module ram_arbiter
    import cpu_types_pkg::*;
(
    input  logic         CLK,
    input  logic         nRST,
    ram_arbiter_if.slave bus
);

    arb_state_t state;
    arb_state_t next_state;
    logic       done_c;
    logic       err_q;
    logic       ram_ren;
    logic       ram_wen;
    logic       iwait_c;
    logic       dwait_c;
    word_t      ram_addr;
    word_t      ram_store;
    word_t      iload_c;
    word_t      dload_c;

    // ERROR is treated as a completion so a requester never hangs
    assign done_c = (bus.ramstate == ACCESS) || (bus.ramstate == ERROR);

`ifdef LLSC_EN
    logic sc_ok;

    llsc_link u_link (
        .CLK         (CLK),
        .nRST        (nRST),
        .rd_done     ((state == DGRANT) && done_c && bus.dREN),
        .wr_done     ((state == DGRANT) && done_c && bus.dWEN),
        .scfail_done (state == SCFAIL),
        .datomic     (bus.datomic),
        .daddr       (bus.daddr),
        .sc_ok       (sc_ok)
    );
`endif

    always_ff @(posedge CLK) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            err_q <= 1'b0;
        end else if (((state == IGRANT) || (state == DGRANT)) && (bus.ramstate == ERROR)) begin
            err_q <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        ram_ren    = 1'b0;
        ram_wen    = 1'b0;
        ram_addr   = '0;
        ram_store  = '0;
        iwait_c    = bus.iREN;
        dwait_c    = bus.dREN | bus.dWEN;
        iload_c    = '0;
        dload_c    = '0;
        unique case (state)
            IDLE: begin
                if (bus.dREN || bus.dWEN) begin
                    next_state = DGRANT;
`ifdef LLSC_EN
                    if (bus.dWEN && bus.datomic && !sc_ok) next_state = SCFAIL;
`endif
                end else if (bus.iREN) begin
                    next_state = IGRANT;
                end
            end
            IGRANT: begin
                ram_ren  = 1'b1;
                ram_addr = bus.iaddr;
                iwait_c  = 1'b1;
                if (done_c) begin
                    iwait_c    = 1'b0;
                    next_state = IDLE;
                    if (bus.ramstate == ACCESS) iload_c = bus.ramload;
                end
            end
            DGRANT: begin
                ram_ren   = bus.dREN;
                ram_wen   = bus.dWEN;
                ram_addr  = bus.daddr;
                ram_store = bus.dstore;
                iwait_c   = 1'b1;
                dwait_c   = 1'b1;
                if (done_c) begin
                    dwait_c    = 1'b0;
                    next_state = IDLE;
                    if (bus.ramstate == ACCESS) begin
                        if (bus.dREN)                       dload_c = bus.ramload;
                        else if (bus.dWEN && bus.datomic)   dload_c = 32'd1;
                    end
                end
            end
            SCFAIL: begin
                dwait_c    = 1'b0;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = ram_addr;
    assign bus.ramstore = ram_store;
    assign bus.iwait    = iwait_c;
    assign bus.dwait    = dwait_c;
    assign bus.iload    = iload_c;
    assign bus.dload    = dload_c;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

`ifdef LLSC_EN
    localparam bit LLSC = 1'b1;
`else
    localparam bit LLSC = 1'b0;
`endif

    logic CLK = 1'b0;
    logic nRST;
    ram_arbiter_if bus ();

    ram_arbiter dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // RAM model storage (what the RAM holds) and reference storage (what the spec predicts)
    word_t ram_mem [word_t];
    word_t ref_mem [word_t];
    int    busy_cfg = 0;
    int    busy_left = 0;
    bit    err_inj = 1'b0;
    bit    prev_strobe = 1'b0;
    bit    lv = 1'b0;
    word_t la = '0;

    logic       o_iwait, o_dwait, o_ren, o_wen, o_err;
    word_t      o_iload, o_dload, o_raddr, o_rstore;
    arb_state_t o_state;

    function automatic word_t ram_rd(input word_t a);
        return ram_mem.exists(a) ? ram_mem[a] : 32'h0;
    endfunction

    function automatic word_t ref_rd(input word_t a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // One clock cycle: RAM responds to the strobes, outputs are sampled, then the edge passes.
    task automatic step();
        logic strobe;
        #1;
        strobe = bus.ramREN | bus.ramWEN;
        if (strobe && !prev_strobe) busy_left = busy_cfg;
        prev_strobe = strobe;
        if (!strobe) begin
            bus.ramstate = FREE;
            bus.ramload  = '0;
        end else if (busy_left > 0) begin
            bus.ramstate = BUSY;
            bus.ramload  = '0;
            busy_left--;
        end else if (err_inj) begin
            bus.ramstate = ERROR;
            bus.ramload  = '0;
        end else begin
            bus.ramstate = ACCESS;
            bus.ramload  = ram_rd(bus.ramaddr);
            if (bus.ramWEN) ram_mem[bus.ramaddr] = bus.ramstore;
        end
        #1;
        o_iwait  = bus.iwait;
        o_dwait  = bus.dwait;
        o_ren    = bus.ramREN;
        o_wen    = bus.ramWEN;
        o_err    = bus.err;
        o_iload  = bus.iload;
        o_dload  = bus.dload;
        o_raddr  = bus.ramaddr;
        o_rstore = bus.ramstore;
        o_state  = dut.state;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.iREN = 1'b0; bus.iaddr = '0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.datomic = 1'b0;
        bus.daddr = '0; bus.dstore = '0;
    endtask

    // Drive one request set, hold it until each wait drops, and report what was observed.
    task automatic txn(input bit ir, input bit dr, input bit dw, input bit at,
                       input word_t ia, input word_t da, input word_t ds,
                       output int i_done, output int d_done, output word_t il, output word_t dl,
                       output int ren_n, output int wen_n, output bit overlap,
                       output word_t i_ra, output word_t d_ra, output word_t d_rs);
        bit ip, dp;
        i_done = 0; d_done = 0; il = '0; dl = '0; ren_n = 0; wen_n = 0; overlap = 1'b0;
        i_ra = '0; d_ra = '0; d_rs = '0;
        bus.iREN = ir; bus.iaddr = ia;
        bus.dREN = dr; bus.dWEN = dw; bus.datomic = at; bus.daddr = da; bus.dstore = ds;
        ip = ir;
        dp = dr | dw;
        for (int c = 1; c <= 60 && (ip || dp); c++) begin
            step();
            if (o_ren) ren_n++;
            if (o_wen) wen_n++;
            if (o_ren && o_wen) overlap = 1'b1;
            if (dp && !o_dwait) begin
                d_done = c; dl = o_dload; d_ra = o_raddr; d_rs = o_rstore; dp = 1'b0;
                bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.datomic = 1'b0; bus.daddr = '0; bus.dstore = '0;
            end
            if (ip && !o_iwait) begin
                i_done = c; il = o_iload; i_ra = o_raddr; ip = 1'b0;
                bus.iREN = 1'b0; bus.iaddr = '0;
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        bus.iREN = 1'b1; bus.dREN = 1'b1;
        step();
        checks++; if (o_state !== IDLE)  begin errors++; $display("FAIL reset_state: got %0d expected %0d", o_state, IDLE); end
        checks++; if ({o_ren, o_wen} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {o_ren, o_wen}); end
        checks++; if ({o_raddr, o_rstore} !== 64'h0) begin errors++; $display("FAIL reset_addr_store: got %h expected 0", {o_raddr, o_rstore}); end
        checks++; if (o_err !== 1'b0)    begin errors++; $display("FAIL reset_err: got %b expected 0", o_err); end
        checks++; if ({o_iwait, o_dwait} !== 2'b11) begin errors++; $display("FAIL reset_waits_follow: got %b expected 11", {o_iwait, o_dwait}); end
        clear_inputs();
        step();
        checks++; if ({o_iwait, o_dwait} !== 2'b00) begin errors++; $display("FAIL reset_waits_idle: got %b expected 00", {o_iwait, o_dwait}); end
        nRST = 1'b1;
        step();
    endtask

    task automatic test_fetch_alone();
        int id, dd, rn, wn; word_t il, dl, ira, dra, drs; bit ov;
        ram_mem[32'h40] = 32'hDEADBEEF;
        busy_cfg = 2;
        txn(1, 0, 0, 0, 32'h40, '0, '0, id, dd, il, dl, rn, wn, ov, ira, dra, drs);
        checks++; if (id !== 4)            begin errors++; $display("FAIL fetch_latency: got %0d expected 4", id); end
        checks++; if (il !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_iload: got %h expected deadbeef", il); end
        checks++; if (rn !== 3)            begin errors++; $display("FAIL fetch_ren_cycles: got %0d expected 3", rn); end
        checks++; if (ira !== 32'h40)      begin errors++; $display("FAIL fetch_ramaddr: got %h expected 40", ira); end
    endtask

    task automatic test_contention();
        int id, dd, rn, wn; word_t il, dl, ira, dra, drs; bit ov;
        ram_mem[32'h100] = 32'h12345678;
        ram_mem[32'h44]  = 32'hCAFE0044;
        busy_cfg = 1;
        txn(1, 1, 0, 0, 32'h44, 32'h100, '0, id, dd, il, dl, rn, wn, ov, ira, dra, drs);
        checks++; if (dd !== 3)            begin errors++; $display("FAIL contention_d_latency: got %0d expected 3", dd); end
        checks++; if (id !== 6)            begin errors++; $display("FAIL contention_i_latency: got %0d expected 6", id); end
        checks++; if (dl !== 32'h12345678) begin errors++; $display("FAIL contention_dload: got %h expected 12345678", dl); end
        checks++; if (il !== 32'hCAFE0044) begin errors++; $display("FAIL contention_iload: got %h expected cafe0044", il); end
        checks++; if (wn !== 0)            begin errors++; $display("FAIL contention_no_wen: got %0d expected 0", wn); end
    endtask

`ifdef LLSC_EN
    task automatic test_llsc();
        int id, dd, rn, wn; word_t il, dl, ira, dra, drs; bit ov;
        busy_cfg = 0;
        txn(0, 1, 0, 1, '0, 32'h200, '0, id, dd, il, dl, rn, wn, ov, ira, dra, drs);
        checks++; if (dd !== 2) begin errors++; $display("FAIL ll_latency: got %0d expected 2", dd); end
        txn(0, 0, 1, 1, '0, 32'h200, 32'd5, id, dd, il, dl, rn, wn, ov, ira, dra, drs);
        checks++; if (dl !== 32'd1) begin errors++; $display("FAIL sc_ok_dload: got %h expected 1", dl); end
        checks++; if (wn !== 1)     begin errors++; $display("FAIL sc_ok_wen: got %0d expected 1", wn); end
        checks++; if ({dra, drs} !== {32'h200, 32'd5}) begin errors++; $display("FAIL sc_ok_write: got %h expected 0000020000000005", {dra, drs}); end
        txn(0, 1, 0, 1, '0, 32'h200, '0, id, dd, il, dl, rn, wn, ov, ira, dra, drs);
        txn(0, 0, 1, 0, '0, 32'h200, 32'd7, id, dd, il, dl, rn, wn, ov, ira, dra, drs);
        txn(0, 0, 1, 1, '0, 32'h200, 32'd9, id, dd, il, dl, rn, wn, ov, ira, dra, drs);
        checks++; if (dd !== 2)     begin errors++; $display("FAIL sc_fail_latency: got %0d expected 2", dd); end
        checks++; if (dl !== 32'd0) begin errors++; $display("FAIL sc_fail_dload: got %h expected 0", dl); end
        checks++; if (wn + rn !== 0) begin errors++; $display("FAIL sc_fail_no_traffic: got %0d expected 0", wn + rn); end
        checks++; if (ram_rd(32'h200) !== 32'd7) begin errors++; $display("FAIL sc_fail_mem: got %h expected 7", ram_rd(32'h200)); end
    endtask
`else
    task automatic test_sc_plain();
        int id, dd, rn, wn; word_t il, dl, ira, dra, drs; bit ov;
        busy_cfg = 0;
        txn(0, 0, 1, 1, '0, 32'h200, 32'd5, id, dd, il, dl, rn, wn, ov, ira, dra, drs);
        checks++; if (dd !== 2)     begin errors++; $display("FAIL sc_plain_latency: got %0d expected 2", dd); end
        checks++; if (dl !== 32'd1) begin errors++; $display("FAIL sc_plain_dload: got %h expected 1", dl); end
        checks++; if (wn !== 1)     begin errors++; $display("FAIL sc_plain_wen: got %0d expected 1", wn); end
        checks++; if (ram_rd(32'h200) !== 32'd5) begin errors++; $display("FAIL sc_plain_mem: got %h expected 5", ram_rd(32'h200)); end
    endtask
`endif

    task automatic test_reset_mid_access();
        int id, dd, rn, wn; word_t il, dl, ira, dra, drs; bit ov;
        busy_cfg = 0;
        txn(0, 1, 0, 1, '0, 32'h208, '0, id, dd, il, dl, rn, wn, ov, ira, dra, drs);
        busy_cfg = 10;
        bus.dREN = 1'b1; bus.daddr = 32'h100;
        step();
        step();
        checks++; if (o_ren !== 1'b1) begin errors++; $display("FAIL mid_granted: got %b expected 1", o_ren); end
        nRST = 1'b0;
        step();
        clear_inputs();
        step();
        checks++; if (o_state !== IDLE) begin errors++; $display("FAIL mid_reset_state: got %0d expected %0d", o_state, IDLE); end
        checks++; if ({o_ren, o_wen, o_err} !== 3'b000) begin errors++; $display("FAIL mid_reset_outputs: got %b expected 000", {o_ren, o_wen, o_err}); end
        nRST = 1'b1;
        busy_cfg = 0;
        txn(0, 0, 1, 1, '0, 32'h208, 32'd3, id, dd, il, dl, rn, wn, ov, ira, dra, drs);
        checks++; if (dl !== (LLSC ? 32'd0 : 32'd1)) begin errors++; $display("FAIL mid_link_cleared: got %h expected %h", dl, LLSC ? 32'd0 : 32'd1); end
    endtask

    task automatic test_error();
        int id, dd, rn, wn; word_t il, dl, ira, dra, drs; bit ov;
        busy_cfg = 1;
        err_inj  = 1'b1;
        txn(1, 0, 0, 0, 32'h48, '0, '0, id, dd, il, dl, rn, wn, ov, ira, dra, drs);
        err_inj  = 1'b0;
        checks++; if (id !== 3) begin errors++; $display("FAIL error_iwait_drop: got %0d expected 3", id); end
        step();
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL error_set: got %b expected 1", o_err); end
        busy_cfg = 0;
        txn(1, 0, 0, 0, 32'h4C, '0, '0, id, dd, il, dl, rn, wn, ov, ira, dra, drs);
        step();
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL error_sticky: got %b expected 1", o_err); end
        nRST = 1'b0;
        step();
        step();
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL error_cleared: got %b expected 0", o_err); end
        nRST = 1'b1;
        step();
        lv = 1'b0;
    endtask

    task automatic test_random();
        int id, dd, rn, wn; word_t il, dl, ira, dra, drs; bit ov;
        word_t addrs [4];
        for (int k = 0; k < 4; k++) begin
            addrs[k] = 32'h300 + 32'(4 * k);
            ram_mem[addrs[k]] = $urandom;
            ref_mem[addrs[k]] = ram_mem[addrs[k]];
        end
        for (int n = 0; n < 40; n++) begin
            bit ir, dr, dw, at, hasd, scfail;
            int dsel, busy, e_d, e_i, e_ren, e_wen;
            word_t ia, da, ds, e_dl, e_il, e_dra, e_drs;
            ir   = 1'($urandom_range(0, 1));
            dsel = $urandom_range(0, 4);
            if (dsel == 0) ir = 1'b1;
            dr   = (dsel == 1) || (dsel == 3);
            dw   = (dsel == 2) || (dsel == 4);
            at   = (dsel >= 3);
            ia   = addrs[$urandom_range(0, 3)];
            da   = addrs[$urandom_range(0, 3)];
            ds   = $urandom;
            busy = $urandom_range(0, 3);
            busy_cfg = busy;
            hasd   = dr | dw;
            scfail = LLSC && dw && at && !(lv && (la == da));
            e_d    = hasd ? (scfail ? 2 : 2 + busy) : 0;
            e_i    = ir ? (hasd ? e_d + 2 + busy : 2 + busy) : 0;
            e_dl   = dr ? ref_rd(da) : ((dw && at && !scfail) ? 32'd1 : 32'd0);
            e_wen  = (dw && !scfail) ? busy + 1 : 0;
            e_ren  = (dr ? busy + 1 : 0) + (ir ? busy + 1 : 0);
            e_dra  = (hasd && !scfail) ? da : 32'h0;
            e_drs  = (hasd && !scfail) ? ds : 32'h0;
            if (dw && !scfail) ref_mem[da] = ds;
            e_il   = ir ? ref_rd(ia) : 32'h0;
            if (LLSC) begin
                if (dr && at)                   begin lv = 1'b1; la = da; end
                else if (dw && (at || da == la)) lv = 1'b0;
            end
            txn(ir, dr, dw, at, ia, da, ds, id, dd, il, dl, rn, wn, ov, ira, dra, drs);
            checks++; if (dd !== e_d)   begin errors++; $display("FAIL rnd%0d_d_latency: got %0d expected %0d", n, dd, e_d); end
            checks++; if (id !== e_i)   begin errors++; $display("FAIL rnd%0d_i_latency: got %0d expected %0d", n, id, e_i); end
            checks++; if (dl !== e_dl)  begin errors++; $display("FAIL rnd%0d_dload: got %h expected %h", n, dl, e_dl); end
            checks++; if (il !== e_il)  begin errors++; $display("FAIL rnd%0d_iload: got %h expected %h", n, il, e_il); end
            checks++; if (wn !== e_wen) begin errors++; $display("FAIL rnd%0d_wen_cycles: got %0d expected %0d", n, wn, e_wen); end
            checks++; if (rn !== e_ren) begin errors++; $display("FAIL rnd%0d_ren_cycles: got %0d expected %0d", n, rn, e_ren); end
            checks++; if (ov !== 1'b0)  begin errors++; $display("FAIL rnd%0d_strobe_overlap: got %b expected 0", n, ov); end
            checks++; if ({dra, drs} !== {e_dra, e_drs}) begin errors++; $display("FAIL rnd%0d_d_addr_store: got %h expected %h", n, {dra, drs}, {e_dra, e_drs}); end
            checks++; if (ira !== (ir ? ia : 32'h0)) begin errors++; $display("FAIL rnd%0d_i_addr: got %h expected %h", n, ira, ir ? ia : 32'h0); end
        end
    endtask

    initial begin
        nRST = 1'b0;
        clear_inputs();
        bus.ramstate = FREE;
        bus.ramload  = '0;
        @(posedge CLK);
        #1;
        test_reset();
        test_fetch_alone();
        test_contention();
`ifdef LLSC_EN
        test_llsc();
`else
        test_sc_plain();
`endif
        test_reset_mid_access();
        test_error();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
